// File: rtl/id_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: ALU/operand encodings,
// opcode and funct3 values, the decoded control bundle and the immediate builder.
package id_stage_pkg;

  localparam int ALU_OP_WIDTH  = 4;
  localparam int ALU_SRC_WIDTH = 2;

  // ALU_AND and ALU_SRC_REG are zero so an all-zero bundle is the reset bundle.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_AND  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_OR   = 4'd9
  } alu_op_e;

  typedef enum logic [ALU_SRC_WIDTH-1:0] {
    ALU_SRC_REG    = 2'd0,
    ALU_SRC_IMM    = 2'd1,
    ALU_SRC_IMM_PC = 2'd2,
    ALU_SRC_FOR_PC = 2'd3
  } alu_src_e;

  typedef enum logic [2:0] {
    IMM_GEN_NONE = 3'd0,
    IMM_GEN_I    = 3'd1,
    IMM_GEN_S    = 3'd2,
    IMM_GEN_B    = 3'd3,
    IMM_GEN_U    = 3'd4,
    IMM_GEN_J    = 3'd5
  } imm_gen_e;

  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_AUIPC  = 7'b0010111;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;
  localparam logic [6:0] INST_BRANCH = 7'b1100011;
  localparam logic [6:0] INST_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_STORE  = 7'b0100011;
  localparam logic [6:0] INST_OP_IMM = 7'b0010011;
  localparam logic [6:0] INST_OP     = 7'b0110011;
  localparam logic [6:0] INST_FENCE  = 7'b0001111;
  localparam logic [6:0] INST_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ZERO = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_wen;
    alu_op_e    alu_op;
    alu_src_e   alu_src;
    logic       branch;
    logic [2:0] branch_op;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       illegal;
  } id_ctrl_t;

  localparam id_ctrl_t ID_CTRL_RESET = '{
    rs1:       5'd0,
    rs2:       5'd0,
    rd:        5'd0,
    reg_wen:   1'b0,
    alu_op:    ALU_AND,
    alu_src:   ALU_SRC_REG,
    branch:    1'b0,
    branch_op: 3'd0,
    jump:      1'b0,
    jalr:      1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    mem_size:  3'd0,
    illegal:   1'b0
  };

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_gen_e sel);
    logic [31:0] imm;
    imm = '0;
    case (sel)
      IMM_GEN_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_GEN_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_GEN_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_GEN_U: imm = {inst[31:12], 12'b0};
      IMM_GEN_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it.
  function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Handshake bundle around the decode stage: fetch-side request and execute-side
// decoded output. The stage itself uses the slave view; the environment the master view.
interface id_stage_if
  import id_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) ();

  logic                     if_valid;
  logic                     if_ready;
  logic [31:0]              if_inst;
  logic [PC_WIDTH-1:0]      if_pc;

  logic                     id_valid;
  logic                     id_ready;
  logic [PC_WIDTH-1:0]      id_pc;
  logic [XLEN-1:0]          id_imm;
  logic [4:0]               id_rs1;
  logic [4:0]               id_rs2;
  logic [4:0]               id_rd;
  logic                     id_reg_wen;
  logic [ALU_OP_WIDTH-1:0]  id_alu_op;
  logic [ALU_SRC_WIDTH-1:0] id_alu_src_sel;
  logic                     id_branch;
  logic [2:0]               id_branch_op;
  logic                     id_jump;
  logic                     id_jalr;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic [2:0]               id_mem_size;
  logic                     id_illegal;

  modport master (
    output if_valid, if_inst, if_pc, id_ready,
    input  if_ready, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_reg_wen,
           id_alu_op, id_alu_src_sel, id_branch, id_branch_op, id_jump, id_jalr,
           id_mem_read, id_mem_write, id_mem_size, id_illegal
  );

  modport slave (
    input  if_valid, if_inst, if_pc, id_ready,
    output if_ready, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_reg_wen,
           id_alu_op, id_alu_src_sel, id_branch, id_branch_op, id_jump, id_jalr,
           id_mem_read, id_mem_write, id_mem_size, id_illegal
  );

endinterface

// File: rtl/id_stage_inst_decode.sv
// Combinational RV32I decoder: instruction word in, unregistered control bundle,
// sign-extended immediate and source-register usage flags out.
module id_stage_inst_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output id_ctrl_t        ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  id_ctrl_t   ctrl;
  imm_gen_e   imm_sel;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;
  logic       illegal;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    ctrl    = ID_CTRL_RESET;
    imm_sel = IMM_GEN_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;

    case (opcode)
      INST_LUI: begin
        use_rd       = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = ALU_SRC_IMM;
        imm_sel      = IMM_GEN_U;
      end
      INST_AUIPC: begin
        use_rd       = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = ALU_SRC_IMM_PC;
        imm_sel      = IMM_GEN_U;
      end
      INST_JAL: begin
        use_rd       = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.jump    = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = ALU_SRC_FOR_PC;
        imm_sel      = IMM_GEN_J;
      end
      INST_JALR: begin
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.jalr    = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = ALU_SRC_FOR_PC;
        imm_sel      = IMM_GEN_I;
        illegal      = (funct3 != 3'b000);
      end
      INST_BRANCH: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.branch_op = funct3;
        imm_sel        = IMM_GEN_B;
        case (funct3)
          F3_BEQ, F3_BNE:   ctrl.alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   ctrl.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: ctrl.alu_op = ALU_SLTU;
          default:          illegal     = 1'b1;
        endcase
      end
      INST_LOAD: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        ctrl.reg_wen  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_size = funct3;
        ctrl.alu_op   = ALU_ADD;
        ctrl.alu_src  = ALU_SRC_IMM;
        imm_sel       = IMM_GEN_I;
        illegal       = !((funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                          (funct3 == F3_LBU) || (funct3 == F3_LHU));
      end
      INST_STORE: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_size  = funct3;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = ALU_SRC_IMM;
        imm_sel        = IMM_GEN_S;
        illegal        = (funct3 > F3_SW);
      end
      INST_OP_IMM: begin
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.alu_src = ALU_SRC_IMM;
        imm_sel      = IMM_GEN_I;
        ctrl.alu_op  = alu_op_from_funct3(funct3, (funct3 == F3_SR) && inst_i[30]);
        if (funct3 == F3_SLL) begin
          illegal = (funct7 != FUNCT7_ZERO);
        end else if (funct3 == F3_SR) begin
          illegal = (funct7 != FUNCT7_ZERO) && (funct7 != FUNCT7_ALT);
        end
      end
      INST_OP: begin
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        ctrl.reg_wen = 1'b1;
        ctrl.alu_src = ALU_SRC_REG;
        ctrl.alu_op  = alu_op_from_funct3(funct3, funct7 == FUNCT7_ALT);
        illegal      = !((funct7 == FUNCT7_ZERO) ||
                         ((funct7 == FUNCT7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
      end
      INST_FENCE: begin
        illegal = 1'b0;
      end
      INST_SYSTEM: begin
        illegal = (inst_i != INST_ECALL) && (inst_i != INST_EBREAK);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    ctrl.rs1     = use_rs1 ? inst_i[19:15] : 5'd0;
    ctrl.rs2     = use_rs2 ? inst_i[24:20] : 5'd0;
    ctrl.rd      = use_rd  ? inst_i[11:7]  : 5'd0;
    ctrl.illegal = illegal;

    // An illegal bundle still issues but must not cause any architectural side effect.
    if (illegal) begin
      ctrl.reg_wen   = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.jalr      = 1'b0;
    end
  end

  assign ctrl_o     = ctrl;
  assign imm_o      = XLEN'($signed(gen_imm(inst_i, imm_sel)));
  assign rs1_used_o = use_rs1;
  assign rs2_used_o = use_rs2;

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: one-entry output register with valid/ready on
// both sides, flush, and a one-bubble load-use stall.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_WIDTH  = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  id_stage_if.slave  bus
);

  id_ctrl_t            dec_ctrl;
  logic [XLEN-1:0]     dec_imm;
  logic                dec_rs1_used;
  logic                dec_rs2_used;

  id_ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]     imm_q, imm_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;

  logic                hazard;
  logic                if_ready;
  logic                if_fire;
  logic                id_fire;

  id_stage_inst_decode #(
    .XLEN(XLEN)
  ) u_inst_decode (
    .inst_i     (bus.if_inst),
    .ctrl_o     (dec_ctrl),
    .imm_o      (dec_imm),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used)
  );

  // A load sitting in the output register blocks any consumer of its rd until it leaves.
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) && bus.if_valid &&
                      ((dec_rs1_used && (dec_ctrl.rs1 == ctrl_q.rd)) ||
                       (dec_rs2_used && (dec_ctrl.rs2 == ctrl_q.rd)));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign if_ready = !flush && !hazard && (!valid_q || bus.id_ready);
  assign if_fire  = bus.if_valid && if_ready;
  assign id_fire  = valid_q && bus.id_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (if_fire) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      imm_d   = dec_imm;
      pc_d    = bus.if_pc;
    end else if (id_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= ID_CTRL_RESET;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.if_ready       = if_ready;
  assign bus.id_valid       = valid_q;
  assign bus.id_pc          = pc_q;
  assign bus.id_imm         = imm_q;
  assign bus.id_rs1         = ctrl_q.rs1;
  assign bus.id_rs2         = ctrl_q.rs2;
  assign bus.id_rd          = ctrl_q.rd;
  assign bus.id_reg_wen     = ctrl_q.reg_wen;
  assign bus.id_alu_op      = ctrl_q.alu_op;
  assign bus.id_alu_src_sel = ctrl_q.alu_src;
  assign bus.id_branch      = ctrl_q.branch;
  assign bus.id_branch_op   = ctrl_q.branch_op;
  assign bus.id_jump        = ctrl_q.jump;
  assign bus.id_jalr        = ctrl_q.jalr;
  assign bus.id_mem_read    = ctrl_q.mem_read;
  assign bus.id_mem_write   = ctrl_q.mem_write;
  assign bus.id_mem_size    = ctrl_q.mem_size;
  assign bus.id_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: one stage with load-use stalling and one without,
// both driven by the same instruction stream.
module tb_id_stage;
  import id_stage_pkg::*;

  localparam logic [31:0] ADDI_X5 = 32'hFFF0_0293;
  localparam logic [31:0] LW_X6   = 32'h0000_A303;
  localparam logic [31:0] ADD_X7  = 32'h0023_03B3;
  localparam logic [31:0] BEQ_M8  = 32'hFE20_8CE3;
  localparam logic [31:0] SRAI_X3 = 32'h4022_5193;
  localparam logic [31:0] ZERO_W  = 32'h0000_0000;

  logic clk;
  logic rst;
  logic flush;
  int   totalChecks;
  int   badChecks;

  id_stage_if #(.XLEN(32), .PC_WIDTH(32)) busHaz ();
  id_stage_if #(.XLEN(32), .PC_WIDTH(32)) busNoHaz ();

  id_stage #(.XLEN(32), .PC_WIDTH(32), .HAZARD_EN(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (busHaz)
  );

  id_stage #(.XLEN(32), .PC_WIDTH(32), .HAZARD_EN(0)) dutNoHaz (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (busNoHaz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic rstV, input logic flushV, input logic validV,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic readyV);
    @(negedge clk);
    rst                = rstV;
    flush              = flushV;
    busHaz.if_valid    = validV;
    busHaz.if_inst     = inst;
    busHaz.if_pc       = pc;
    busHaz.id_ready    = readyV;
    busNoHaz.if_valid  = validV;
    busNoHaz.if_inst   = inst;
    busNoHaz.if_pc     = pc;
    busNoHaz.id_ready  = readyV;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    totalChecks       = 0;
    badChecks         = 0;
    rst               = 1'b1;
    flush             = 1'b0;
    busHaz.if_valid   = 1'b0;
    busHaz.if_inst    = 32'd0;
    busHaz.if_pc      = 32'd0;
    busHaz.id_ready   = 1'b1;
    busNoHaz.if_valid = 1'b0;
    busNoHaz.if_inst  = 32'd0;
    busNoHaz.if_pc    = 32'd0;
    busNoHaz.id_ready = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1, ADDI_X5, 32'h100, 1'b1);
    checkOutput("reset_valid",   32'(busHaz.id_valid), 32'd0);
    checkOutput("reset_imm",     busHaz.id_imm, 32'd0);
    checkOutput("reset_rd",      32'(busHaz.id_rd), 32'd0);
    checkOutput("reset_alu_op",  32'(busHaz.id_alu_op), 32'(ALU_AND));
    checkOutput("reset_alu_src", 32'(busHaz.id_alu_src_sel), 32'(ALU_SRC_REG));
    checkOutput("reset_ifready", 32'(busHaz.if_ready), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, LW_X6, 32'h104, 1'b1);
    checkOutput("addi_valid",   32'(busHaz.id_valid), 32'd1);
    checkOutput("addi_imm",     busHaz.id_imm, 32'hFFFF_FFFF);
    checkOutput("addi_rd",      32'(busHaz.id_rd), 32'd5);
    checkOutput("addi_rs1",     32'(busHaz.id_rs1), 32'd0);
    checkOutput("addi_alu_op",  32'(busHaz.id_alu_op), 32'(ALU_ADD));
    checkOutput("addi_alu_src", 32'(busHaz.id_alu_src_sel), 32'(ALU_SRC_IMM));
    checkOutput("addi_pc",      busHaz.id_pc, 32'h100);
    checkOutput("addi_reg_wen", 32'(busHaz.id_reg_wen), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, ADD_X7, 32'h108, 1'b1);
    checkOutput("lw_valid",          32'(busHaz.id_valid), 32'd1);
    checkOutput("lw_mem_read",       32'(busHaz.id_mem_read), 32'd1);
    checkOutput("lw_rd",             32'(busHaz.id_rd), 32'd6);
    checkOutput("lw_mem_size",       32'(busHaz.id_mem_size), 32'd2);
    checkOutput("lw_hazard_ifready", 32'(busHaz.if_ready), 32'd0);
    checkOutput("nohaz_ifready",     32'(busNoHaz.if_ready), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b1, ADD_X7, 32'h108, 1'b1);
    checkOutput("bubble_valid",   32'(busHaz.id_valid), 32'd0);
    checkOutput("bubble_ifready", 32'(busHaz.if_ready), 32'd1);
    checkOutput("nohaz_add_valid", 32'(busNoHaz.id_valid), 32'd1);
    checkOutput("nohaz_add_rd",    32'(busNoHaz.id_rd), 32'd7);

    applyStimulus(1'b0, 1'b0, 1'b1, BEQ_M8, 32'h10C, 1'b1);
    checkOutput("add_valid",   32'(busHaz.id_valid), 32'd1);
    checkOutput("add_rs1",     32'(busHaz.id_rs1), 32'd6);
    checkOutput("add_rs2",     32'(busHaz.id_rs2), 32'd2);
    checkOutput("add_rd",      32'(busHaz.id_rd), 32'd7);
    checkOutput("add_alu_src", 32'(busHaz.id_alu_src_sel), 32'(ALU_SRC_REG));
    checkOutput("add_pc",      busHaz.id_pc, 32'h108);

    applyStimulus(1'b0, 1'b0, 1'b1, SRAI_X3, 32'h110, 1'b0);
    checkOutput("beq_imm",       busHaz.id_imm, 32'hFFFF_FFF8);
    checkOutput("beq_branch",    32'(busHaz.id_branch), 32'd1);
    checkOutput("beq_branch_op", 32'(busHaz.id_branch_op), 32'd0);
    checkOutput("beq_rd",        32'(busHaz.id_rd), 32'd0);
    checkOutput("beq_rs2",       32'(busHaz.id_rs2), 32'd2);
    checkOutput("beq_ifready",   32'(busHaz.if_ready), 32'd0);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, SRAI_X3, 32'h110, 1'b0);
      checkOutput("hold_valid",   32'(busHaz.id_valid), 32'd1);
      checkOutput("hold_imm",     busHaz.id_imm, 32'hFFFF_FFF8);
      checkOutput("hold_pc",      busHaz.id_pc, 32'h10C);
      checkOutput("hold_branch",  32'(busHaz.id_branch), 32'd1);
      checkOutput("hold_ifready", 32'(busHaz.if_ready), 32'd0);
    end

    applyStimulus(1'b0, 1'b0, 1'b1, SRAI_X3, 32'h110, 1'b1);
    checkOutput("release_pc",      busHaz.id_pc, 32'h10C);
    checkOutput("release_ifready", 32'(busHaz.if_ready), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b0, ZERO_W, 32'h0, 1'b1);
    checkOutput("srai_alu_op",  32'(busHaz.id_alu_op), 32'(ALU_SRA));
    checkOutput("srai_illegal", 32'(busHaz.id_illegal), 32'd0);
    checkOutput("srai_rd",      32'(busHaz.id_rd), 32'd3);
    checkOutput("srai_rs1",     32'(busHaz.id_rs1), 32'd4);
    checkOutput("srai_imm",     busHaz.id_imm, 32'h0000_0402);

    applyStimulus(1'b0, 1'b0, 1'b1, ZERO_W, 32'h114, 1'b1);
    checkOutput("drain_valid", 32'(busHaz.id_valid), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, ADDI_X5, 32'h118, 1'b0);
    checkOutput("zero_valid",   32'(busHaz.id_valid), 32'd1);
    checkOutput("zero_illegal", 32'(busHaz.id_illegal), 32'd1);
    checkOutput("zero_reg_wen", 32'(busHaz.id_reg_wen), 32'd0);
    checkOutput("zero_pc",      busHaz.id_pc, 32'h114);
    checkOutput("flush_ifready", 32'(busHaz.if_ready), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, ZERO_W, 32'h0, 1'b1);
    checkOutput("flushed_valid", 32'(busHaz.id_valid), 32'd0);
    checkOutput("flushed_pc",    busHaz.id_pc, 32'h114);

    applyStimulus(1'b0, 1'b0, 1'b1, LW_X6, 32'h120, 1'b1);
    checkOutput("idle_ifready", 32'(busHaz.if_ready), 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b1, ADD_X7, 32'h124, 1'b1);
    checkOutput("flushhaz_lw_valid", 32'(busHaz.id_valid), 32'd1);
    checkOutput("flushhaz_ifready",  32'(busHaz.if_ready), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, ZERO_W, 32'h0, 1'b1);
    checkOutput("flushhaz_valid", 32'(busHaz.id_valid), 32'd0);
    checkOutput("flushhaz_pc",    busHaz.id_pc, 32'h120);

    applyStimulus(1'b0, 1'b0, 1'b1, LW_X6, 32'h130, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, ADD_X7, 32'h134, 1'b0);
    checkOutput("stall_valid",   32'(busHaz.id_valid), 32'd1);
    checkOutput("stall_ifready", 32'(busHaz.if_ready), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, ADD_X7, 32'h134, 1'b0);
    checkOutput("stall_mem_read", 32'(busHaz.id_mem_read), 32'd1);

    applyStimulus(1'b0, 1'b0, 1'b0, ZERO_W, 32'h0, 1'b1);
    checkOutput("midrst_valid",    32'(busHaz.id_valid), 32'd0);
    checkOutput("midrst_pc",       busHaz.id_pc, 32'd0);
    checkOutput("midrst_rd",       32'(busHaz.id_rd), 32'd0);
    checkOutput("midrst_mem_read", 32'(busHaz.id_mem_read), 32'd0);
    checkOutput("midrst_alu_op",   32'(busHaz.id_alu_op), 32'(ALU_AND));
    checkOutput("midrst_ifready",  32'(busHaz.if_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
